// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types and constants for the host transmitter and keyboard receiver.
//   ps2_tx_state_t : host transmit FSM states
//   PS2_CMD_*      : host-to-device command bytes
//   PS2_RSP_ACK    : device acknowledge response byte
//   odd_parity()   : PS/2 frame parity bit for a data byte
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, WAIT_IDLE} ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    // Bit count reached on the ACK edge (start is implicit, 8 data, parity, stop, ack).
    localparam logic [3:0] PS2_ACK_BIT = 4'd11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer with falling-edge strobe for one PS/2 line.
//   clock, reset : system clock, asynchronous active-high reset
//   line_in      : asynchronous pad level
//   line_sync    : synchronized level
//   fall         : one-cycle strobe, synchronized level went 1 -> 0
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic line_sync,
    output logic fall
);

    logic meta;
    logic prev;

    // Lines idle high, so resetting to 1 avoids a false edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            prev      <= 1'b1;
        end else begin
            meta      <= line_in;
            line_sync <= meta;
            prev      <= line_sync;
        end
    end

    assign fall = prev & ~line_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, RTS, shift-out, ACK check, timeout).
//   clock, reset                     : system clock, asynchronous active-high reset
//   device_clock_in, device_data_in  : PS/2 pad levels (asynchronous)
//   device_clock_oe, device_data_oe  : 1 pulls the corresponding open-collector line low
//   tx_data, tx_valid, tx_ready      : command byte handshake, accepted on tx_valid & tx_ready
//   busy                             : transaction in progress
//   tx_done                          : pulse, byte sent and acknowledged
//   tx_error, tx_nack                : pulse on NACK or timeout; tx_nack tells which and holds
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter logic [15:0] INHIBIT_CYCLES = 16'd5000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       device_clock_in,
    input  logic       device_data_in,
    output logic       device_clock_oe,
    output logic       device_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic       tx_nack
);

    ps2_tx_state_t state, state_next;
    logic [8:0]  frame;
    logic [3:0]  bit_cnt;
    logic [23:0] timer;
    logic        ack_ok;
    logic        nack_q;
    logic        clk_s, clk_fall, dat_s, dat_fall;
    logic        inhibit_done, timeout, lines_idle, wait_fire, shift_low;

    ps2_line_sync u_clock_sync (
        .clock    (clock),
        .reset    (reset),
        .line_in  (device_clock_in),
        .line_sync(clk_s),
        .fall     (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clock    (clock),
        .reset    (reset),
        .line_in  (device_data_in),
        .line_sync(dat_s),
        .fall     (dat_fall)
    );

    assign inhibit_done = timer == {8'd0, INHIBIT_CYCLES} - 24'd1;
    assign timeout      = (state == SHIFT || state == WAIT_IDLE) && timer == TIMEOUT_CYCLES;
    assign lines_idle   = clk_s && dat_s && !dat_fall;
    assign wait_fire    = state == WAIT_IDLE && !timeout && lines_idle;
    // Before the first device edge the start bit (0) is still on the line;
    // counts 1..9 carry data LSB first then parity; 10 and beyond release data.
    assign shift_low    = bit_cnt == 4'd0 ? 1'b1 :
                          bit_cnt <= 4'd9 ? ~frame[bit_cnt - 4'd1] : 1'b0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = tx_valid ? INHIBIT : IDLE;
            INHIBIT:   state_next = inhibit_done ? RTS : INHIBIT;
            RTS:       state_next = SHIFT;
            SHIFT:     state_next = timeout ? IDLE :
                                    (clk_fall && bit_cnt == PS2_ACK_BIT - 4'd1) ? WAIT_IDLE : SHIFT;
            WAIT_IDLE: state_next = (timeout || lines_idle) ? IDLE : WAIT_IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_ready        = state == IDLE;
        busy            = state != IDLE;
        device_clock_oe = state == INHIBIT || state == RTS;
        device_data_oe  = state == RTS || (state == SHIFT && !timeout && shift_low);
        tx_done         = wait_fire && ack_ok;
        tx_error        = timeout || (wait_fire && !ack_ok);
        tx_nack         = tx_error ? !timeout : nack_q;
    end

    // The shared timer counts the inhibit interval, then restarts at clock
    // release to measure the whole-transaction timeout, saturating there.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame   <= 9'd0;
            bit_cnt <= 4'd0;
            timer   <= 24'd0;
            ack_ok  <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            if (state == IDLE && tx_valid) begin
                frame   <= {odd_parity(tx_data), tx_data};
                bit_cnt <= 4'd0;
                timer   <= 24'd0;
                nack_q  <= 1'b0;
            end
            if (state == INHIBIT) begin
                timer <= inhibit_done ? 24'd0 : timer + 24'd1;
            end
            if (state == RTS) begin
                timer <= 24'd0;
            end
            if (state == SHIFT || state == WAIT_IDLE) begin
                timer <= timer == TIMEOUT_CYCLES ? timer : timer + 24'd1;
            end
            if (state == SHIFT && clk_fall && bit_cnt != PS2_ACK_BIT) begin
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == PS2_ACK_BIT - 4'd1) begin
                    ack_ok <= ~dat_s;
                end
            end
            if (tx_error) begin
                nack_q <= !timeout;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 30;
    localparam int TMO = 1000;
    localparam int H   = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;
    logic       device_clock_oe, device_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error, tx_nack;

    assign clk_line  = ~(device_clock_oe | dev_clk_low);
    assign data_line = ~(device_data_oe | dev_data_low);

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES(16'(INH)),
        .TIMEOUT_CYCLES(24'(TMO))
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .device_clock_in(clk_line),
        .device_data_in (data_line),
        .device_clock_oe(device_clock_oe),
        .device_data_oe (device_data_oe),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .tx_done        (tx_done),
        .tx_error       (tx_error),
        .tx_nack        (tx_nack)
    );

    typedef struct {
        logic       done;
        logic       nack;
        logic [7:0] data;
        logic       par;
        logic       chk_bits;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         release_cyc = 0;
    int         inh_run = 0;
    int         ready_bad_cnt = 0;
    logic [9:0] dev_bits = 10'd0;
    logic       last_coe = 1'b0;
    logic       post = 1'b0;
    logic       post_nack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: tracks clock release, inhibit length and tx_ready misuse, and
    // pops the scoreboard whenever the DUT reports a completed transaction.
    always @(negedge clock) begin
        last_coe <= device_clock_oe;
        if (last_coe && !device_clock_oe) release_cyc <= cyc;
        if (device_clock_oe && !device_data_oe) inh_run <= inh_run + 1;
        else if (!device_clock_oe) inh_run <= 0;
        if (busy && tx_ready) ready_bad_cnt <= ready_bad_cnt + 1;
        if (post) begin
            check("post_ready", tx_ready, 1);
            check("post_clock_oe", device_clock_oe, 0);
            check("post_data_oe", device_data_oe, 0);
            check("post_nack_hold", tx_nack, post_nack);
            post <= 1'b0;
        end
        if (tx_done || tx_error) begin
            if (sb.size() == 0) begin
                bound_fail("unexpected_pulse");
            end else begin
                e = sb.pop_front();
                check("done_pulse", tx_done, e.done);
                check("error_pulse", tx_error, !e.done);
                if (!e.done) check("nack_kind", tx_nack, e.nack);
                if (e.chk_bits) begin
                    check("line_data", dev_bits[7:0], e.data);
                    check("line_parity", dev_bits[8], e.par);
                    check("line_stop", dev_bits[9], 1);
                end
                if (e.lat >= 0) check("timeout_latency", cyc - release_cyc, e.lat);
                post      <= 1'b1;
                post_nack <= e.done ? 1'b0 : e.nack;
            end
        end
    end

    task automatic push(input logic done, input logic nack, input logic [7:0] data,
                        input logic par, input logic chk, input int lat);
        exp_t x;
        x.done = done; x.nack = nack; x.data = data; x.par = par; x.chk_bits = chk; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        @(negedge clock);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && t < 100) begin @(negedge clock); t++; end
        if (!tx_ready) bound_fail("accept");
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    // Device model: waits for RTS, checks inhibit and start bit, then clocks
    // out up to 11 edges, sampling host data on each rising edge.
    task automatic dev_run(input bit ack, input int stop_edge);
        int t = 0;
        while (!(device_clock_oe && device_data_oe) && t < 5000) begin @(negedge clock); t++; end
        if (!(device_clock_oe && device_data_oe)) begin bound_fail("rts"); return; end
        check("inhibit_len", inh_run >= INH, 1);
        t = 0;
        while (device_clock_oe && t < 100) begin @(negedge clock); t++; end
        check("start_bit", data_line, 0);
        if (stop_edge == 0) return;
        for (int k = 1; k <= 11; k++) begin
            repeat (H) @(negedge clock);
            if (k == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (H / 2) @(negedge clock);
            end
            dev_clk_low = 1'b1;
            if (k == stop_edge) return;
            repeat (H) @(negedge clock);
            dev_clk_low = 1'b0;
            if (k <= 10) dev_bits[k-1] = data_line;
        end
        repeat (H) @(negedge clock);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_sb();
        int t = 0;
        while (sb.size() != 0 && t < 3 * TMO) begin @(negedge clock); t++; end
        if (sb.size() != 0) bound_fail("response");
        repeat (3) @(negedge clock);
    endtask

    task automatic normal(input logic [7:0] b, input logic par);
        int base = ready_bad_cnt;
        push(1'b1, 1'b0, b, par, 1'b1, -1);
        send(b);
        dev_run(1'b1, 12);
        wait_sb();
        check("ready_low_busy", ready_bad_cnt - base, 0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clock);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clock_oe", device_clock_oe, 0);
        check("rst_data_oe", device_data_oe, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        check("rst_nack", tx_nack, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        normal(PS2_CMD_SET_LEDS, 1'b1);
        normal(PS2_CMD_ENABLE, 1'b0);
        normal(8'h00, 1'b1);

        push(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, -1);
        send(8'hA5);
        dev_run(1'b0, 12);
        wait_sb();

        push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, TMO);
        send(PS2_CMD_SET_LEDS);
        dev_run(1'b0, 0);
        wait_sb();

        send(PS2_CMD_RESET);
        dev_run(1'b1, 5);
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_clock_oe", device_clock_oe, 0);
        check("async_data_oe", device_data_oe, 0);
        check("async_busy", busy, 0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        normal(PS2_CMD_RESET, 1'b1);

        base = ready_bad_cnt;
        push(1'b1, 1'b0, PS2_CMD_RESET, 1'b1, 1'b1, -1);
        send(PS2_CMD_RESET);
        repeat (5) @(negedge clock);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        repeat (3) @(negedge clock);
        tx_valid = 1'b0;
        dev_run(1'b1, 12);
        wait_sb();
        check("ready_low_busy_ignore", ready_bad_cnt - base, 0);
        check("busy_after_ignore", busy, 0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, for example FF (reset), ED (set LEDs) and F4 (enable).
- Drives the shared open-collector PS/2 clock and data lines through active-high pull-low enables, alongside the existing keyboard receiver.
- Performs inhibit, request-to-send, 11-bit frame shift-out and ACK check, with a whole-transaction timeout.
- Asserts busy during a transaction so the receiver path can ignore its own traffic.

Parameters:
- INHIBIT_CYCLES, 16'd5000: clock cycles that device_clock_oe holds the clock low before RTS (100 us at 50 MHz).
- TIMEOUT_CYCLES, 24'd750000: clock cycles from release of the clock until the transaction must complete (15 ms at 50 MHz).

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- device_clock_in  in  1  PS/2 clock line as seen at the pad (asynchronous)
- device_data_in  in  1  PS/2 data line as seen at the pad (asynchronous)
- device_clock_oe  out  1  1 = pull clock line low, 0 = release
- device_data_oe  out  1  1 = pull data line low, 0 = release
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  1 in IDLE only; a byte is accepted when tx_valid & tx_ready
- busy  out  1  1 in every state except IDLE
- tx_done  out  1  one-cycle pulse: byte sent and ACK received
- tx_error  out  1  one-cycle pulse: NACK or timeout
- tx_nack  out  1  qualifies tx_error: 1 = NACK, 0 = timeout

Behaviour:
- Reset values: all outputs 0 except tx_ready = 1. Both lines are released immediately (asynchronous), so reset mid-frame never leaves a line held low.
- Inputs pass through a 2-FF synchronizer. A falling edge is sync_prev = 1 and sync_cur = 0, detected one cycle after the synchronizer.
- On acceptance, latch frame = {odd parity = ~^tx_data, tx_data}. Clear the bit counter (4-bit) and the timer. tx_ready drops the next cycle.
- IDLE: oe outputs both 0. When tx_valid is seen, go to INHIBIT. tx_valid while not in IDLE is ignored; the requester holds it until tx_ready.
- INHIBIT: device_clock_oe = 1, device_data_oe = 0, for INHIBIT_CYCLES cycles. Then go to RTS.
- RTS: one cycle with device_data_oe = 1 (start bit 0) and device_clock_oe = 1. Then release the clock (device_clock_oe = 0), start the timeout timer, and go to SHIFT.
- SHIFT: on each device clock falling edge, increment the bit counter n and drive the next bit (device_data_oe = ~bit):
  - n = 1..8: drive data bit n-1, LSB first.
  - n = 9: drive parity.
  - n = 10: release data (stop bit = 1).
  - n = 11: sample synced data. If 0, go to WAIT_IDLE with ack_ok = 1. If 1, go to WAIT_IDLE with ack_ok = 0.
- WAIT_IDLE: wait until synced clock and data are both 1.
  - If ack_ok, pulse tx_done.
  - Otherwise pulse tx_error with tx_nack = 1.
  - Then return to IDLE.
- Timeout: the timer runs in SHIFT and WAIT_IDLE. When it reaches TIMEOUT_CYCLES:
  - release both lines;
  - pulse tx_error with tx_nack = 0;
  - go to IDLE on the same cycle, taking priority over any simultaneous edge.
- tx_done and tx_error are mutually exclusive. tx_nack is held until the next acceptance.
- The timer saturates and never wraps. The bit counter never exceeds 11.
- Device replies (FA/FE) are received by the receiver block, not by this one.

Decomposition:
- Shared package ps2_pkg:
  - state enum {IDLE, INHIBIT, RTS, SHIFT, WAIT_IDLE};
  - command constants PS2_CMD_RESET = 8'hFF, PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_ENABLE = 8'hF4, PS2_CMD_RESEND = 8'hFE, PS2_RSP_ACK = 8'hFA.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge strobe for one line. It is instantiated twice and is reusable by the receiver.

Test Plan:
- Send 0xED; a device model clocks at 12.5 kHz and ACKs. Required: INHIBIT ≥ 5000 cycles, start bit 0, data bits 1,0,1,1,0,1,1,1, parity 1, data released at edge 10, then tx_done pulse and tx_ready = 1.
- Send 0xF4 and 0x00. Required: parity bits 0 and 1 respectively, and the 8 data bits match LSB-first order exactly.
- The device samples edge 11 with data high (no ACK). Required: tx_error = 1, tx_nack = 1, tx_done never asserted, both oe = 0.
- The device never clocks after RTS. Required: tx_error with tx_nack = 0 exactly TIMEOUT_CYCLES after clock release, lines released, tx_ready = 1 the next cycle.
- Assert reset at edge 5 of a 0xFF frame. Required: both oe = 0 asynchronously, no done or error pulse, and a following 0xFF transmission completes normally.
- Pulse tx_valid with 0x11 while busy, then send 0xFF. Required: only 0xFF appears on the line, and tx_ready stays low for the whole transaction.
